// File: rtl/keypad_loader_pkg.sv
// Shared types and constants for the microwave keypad loader.
// Holds the FSM state encoding, digit limits and the quick-start increment.
// Also provides the saturating BCD "+30 s" helper used by quick-start.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4
  } state_e;

  localparam int unsigned DIGITS_DEFAULT       = 3;
  localparam int unsigned KEY_MAX              = 9;
  localparam int unsigned SEC_TENS_MAX_DEFAULT = 5;
  localparam int unsigned QUICK_SECS           = 30;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  // Add QUICK_SECS to an M:SS value; seconds carry into minutes, 9:59 cap.
  function automatic bcd_time_t add_quick(input bcd_time_t t);
    bcd_time_t r;
    int        tens;
    int        mins;
    tens = int'(t.sec_tens) + int'(QUICK_SECS / 10);
    mins = int'(t.min);
    if (tens > 5) begin
      tens = tens - 6;
      mins = mins + 1;
    end
    if (mins > 9) begin
      r.min      = 4'd9;
      r.sec_tens = 4'd5;
      r.sec_ones = 4'd9;
    end else begin
      r.min      = 4'(mins);
      r.sec_tens = 4'(tens);
      r.sec_ones = t.sec_ones;
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_loader_bcd_shift_reg.sv
// BCD entry register: shifts a new digit in at the least-significant end.
// Latency: one cycle from control strobe to updated contents.
// Priority: sync reset, then clear, then parallel load, then shift.
module bcd_shift_reg #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   clear_i,
  input  logic                   shift_i,
  input  logic [3:0]             digit_i,
  input  logic                   load_i,
  input  logic [DIGITS-1:0][3:0] load_dat_i,
  output logic [DIGITS-1:0][3:0] q_o
);

  logic [DIGITS-1:0][3:0] dig_q;
  logic [DIGITS-1:0][3:0] dig_d;

  // Select the next register contents; the oldest digit falls off on shift.
  always_comb begin
    dig_d = dig_q;
    if (clear_i) begin
      dig_d = '0;
    end else if (load_i) begin
      dig_d = load_dat_i;
    end else if (shift_i) begin
      dig_d = {dig_q[DIGITS-2:0], digit_i};
    end
  end

  // Digit storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      dig_q <= '0;
    end else begin
      dig_q <= dig_d;
    end
  end

  assign q_o = dig_q;

endmodule

// File: rtl/keypad_loader.sv
// Keypad loader: collects M:SS digits, loads the countdown chain, runs it.
// Latency: key->data 1 cycle, start->loadn low 1 cycle, start->en 2 cycles.
// Optional KEYPAD_QUICK_START_EN: start in IDLE loads 0:30, start in RUN adds 30 s.
module keypad_loader
  import microwave_pkg::*;
#(
  parameter int unsigned DIGITS       = DIGITS_DEFAULT,
  parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       timer_zero,
  output logic [3:0] data_min,
  output logic [3:0] data_sec_tens,
  output logic [3:0] data_sec_ones,
  output logic       loadn,
  output logic       en,
  output logic       running,
  output logic       done,
  output logic       entry_err
);

  localparam logic [3:0] KEY_MAX_L      = 4'(KEY_MAX);
  localparam logic [3:0] SEC_TENS_MAX_L = 4'(SEC_TENS_MAX);

  state_e                 state_q, state_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [DIGITS-1:0][3:0] digits;
  logic                   sr_clear, sr_shift, sr_load;
  logic [DIGITS-1:0][3:0] sr_load_dat;
  logic                   key_ok;
  logic                   entry_bad;

  assign key_ok    = key_valid && (key_code <= KEY_MAX_L);
  assign entry_bad = (digits[1] > SEC_TENS_MAX_L) || (digits == '0);

  bcd_shift_reg #(.DIGITS(DIGITS)) u_digits (
    .clk        (clk),
    .clr        (clr),
    .clear_i    (sr_clear),
    .shift_i    (sr_shift),
    .digit_i    (key_code),
    .load_i     (sr_load),
    .load_dat_i (sr_load_dat),
    .q_o        (digits)
  );

  // State and one-cycle pulse registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state plus entry-register control; stop beats start, zero beats stop.
  always_comb begin
    state_d     = state_q;
    sr_clear    = 1'b0;
    sr_shift    = 1'b0;
    sr_load     = 1'b0;
    sr_load_dat = digits;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef KEYPAD_QUICK_START_EN
        if (start_btn && !stop_btn) begin
          sr_load     = 1'b1;
          sr_load_dat = '0;
          sr_load_dat[1] = 4'(QUICK_SECS / 10);
          state_d     = LOAD;
        end else
`endif
        if (key_ok) begin
          sr_shift = 1'b1;
          state_d  = ENTRY;
        end
      end
      ENTRY: begin
        if (stop_btn) begin
          sr_clear = 1'b1;
          state_d  = IDLE;
        end else if (start_btn) begin
          // A simultaneous key is dropped; start alone decides.
          if (entry_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else if (key_ok) begin
          sr_shift = 1'b1;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        if (timer_zero) begin
          sr_clear = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (stop_btn) begin
          state_d = PAUSE;
        end
`ifdef KEYPAD_QUICK_START_EN
        else if (start_btn) begin
          sr_load     = 1'b1;
          sr_load_dat = add_quick(bcd_time_t'(digits));
          state_d     = LOAD;
        end
`endif
      end
      PAUSE: begin
        if (stop_btn) begin
          sr_clear = 1'b1;
          state_d  = IDLE;
        end else if (start_btn) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Countdown-chain handshake and status outputs decoded from state.
  always_comb begin
    loadn   = (state_q != LOAD);
    en      = (state_q == RUN);
    running = (state_q == LOAD) || (state_q == RUN);
  end

  assign data_min      = digits[DIGITS-1];
  assign data_sec_tens = digits[1];
  assign data_sec_ones = digits[0];
  assign done          = done_q;
  assign entry_err     = err_q;

endmodule

// File: tb/tb_keypad_loader.sv
// Directed bench for keypad_loader: each step queues the outputs expected
// after the coming clock edge; the next step pops and compares them.
module tb_keypad_loader;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       timer_zero = 1'b0;
  logic [3:0] data_min, data_sec_tens, data_sec_ones;
  logic       loadn, en, running, done, entry_err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [16:0] exp_q[$];
  string       tag_q[$];

  keypad_loader dut (
    .clk           (clk),
    .clr           (clr),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .start_btn     (start_btn),
    .stop_btn      (stop_btn),
    .timer_zero    (timer_zero),
    .data_min      (data_min),
    .data_sec_tens (data_sec_tens),
    .data_sec_ones (data_sec_ones),
    .loadn         (loadn),
    .en            (en),
    .running       (running),
    .done          (done),
    .entry_err     (entry_err)
  );

  always #5 clk = ~clk;

  // {min, sec_tens, sec_ones, loadn, en, running, done, entry_err}
  function automatic logic [16:0] ev(input int m, input int t, input int o,
                                     input int lo, input int e, input int r,
                                     input int d, input int er);
    return {4'(m), 4'(t), 4'(o), 1'(lo), 1'(e), 1'(r), 1'(d), 1'(er)};
  endfunction

  task automatic check_pop();
    logic [16:0] e;
    logic [16:0] obs;
    string       t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {data_min, data_sec_tens, data_sec_ones, loadn, en, running, done, entry_err};
      n_checks++;
      assert (obs === e) else begin
        n_fails++;
        $display("FAIL %s observed=%h expected=%h (min,st,so,loadn,en,run,done,err)", t, obs, e);
        $error("check %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // Compare the previous step's outcome, then drive this step's inputs.
  task automatic drv(input string tag, input int c, input int kv, input int kc,
                     input int st, input int sp, input int tz, input logic [16:0] e);
    @(negedge clk);
    check_pop();
    clr        = (c != 0);
    key_valid  = (kv != 0);
    key_code   = 4'(kc);
    start_btn  = (st != 0);
    stop_btn   = (sp != 0);
    timer_zero = (tz != 0);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin
    //   tag            clr kv kc st sp tz   expected after edge
    drv("reset",        1, 0, 0, 0, 0, 0, ev(0,0,0, 1,0,0,0,0));
    drv("idle",         0, 0, 0, 0, 0, 0, ev(0,0,0, 1,0,0,0,0));
    drv("key1",         0, 1, 1, 0, 0, 0, ev(0,0,1, 1,0,0,0,0));
    drv("key3",         0, 1, 3, 0, 0, 0, ev(0,1,3, 1,0,0,0,0));
    drv("key0",         0, 1, 0, 0, 0, 0, ev(1,3,0, 1,0,0,0,0));
    drv("start_load",   0, 0, 0, 1, 0, 0, ev(1,3,0, 0,0,1,0,0));
    drv("load_tz_ign",  0, 0, 0, 0, 0, 1, ev(1,3,0, 1,1,1,0,0));
    drv("run_key_ign",  0, 1, 5, 0, 0, 0, ev(1,3,0, 1,1,1,0,0));
    drv("pause",        0, 0, 0, 0, 1, 0, ev(1,3,0, 1,0,0,0,0));
    drv("pause_hold",   0, 0, 0, 0, 0, 0, ev(1,3,0, 1,0,0,0,0));
    drv("resume",       0, 0, 0, 1, 0, 0, ev(1,3,0, 1,1,1,0,0));
    drv("pause2",       0, 0, 0, 0, 1, 0, ev(1,3,0, 1,0,0,0,0));
    drv("cancel",       0, 0, 0, 0, 1, 0, ev(0,0,0, 1,0,0,0,0));
    drv("key12_ign",    0, 1,12, 0, 0, 0, ev(0,0,0, 1,0,0,0,0));
    drv("idle_start",   0, 0, 0, 1, 0, 0, ev(0,0,0, 1,0,0,0,0));
    drv("k170_1",       0, 1, 1, 0, 0, 0, ev(0,0,1, 1,0,0,0,0));
    drv("k170_7",       0, 1, 7, 0, 0, 0, ev(0,1,7, 1,0,0,0,0));
    drv("k170_0",       0, 1, 0, 0, 0, 0, ev(1,7,0, 1,0,0,0,0));
    drv("bad_tens",     0, 0, 0, 1, 0, 0, ev(1,7,0, 1,0,0,0,1));
    drv("err_once",     0, 0, 0, 0, 0, 0, ev(1,7,0, 1,0,0,0,0));
    drv("key_w_start",  0, 1, 4, 1, 0, 0, ev(1,7,0, 1,0,0,0,1));
    drv("err_clear",    0, 0, 0, 0, 0, 0, ev(1,7,0, 1,0,0,0,0));
    drv("roll_2",       0, 1, 2, 0, 0, 0, ev(7,0,2, 1,0,0,0,0));
    drv("roll_3",       0, 1, 3, 0, 0, 0, ev(0,2,3, 1,0,0,0,0));
    drv("roll_4",       0, 1, 4, 0, 0, 0, ev(2,3,4, 1,0,0,0,0));
    drv("start234",     0, 0, 0, 1, 0, 0, ev(2,3,4, 0,0,1,0,0));
    drv("run234",       0, 0, 0, 0, 0, 0, ev(2,3,4, 1,1,1,0,0));
    drv("zero",         0, 0, 0, 0, 0, 1, ev(0,0,0, 1,0,0,1,0));
    drv("done_once",    0, 0, 0, 0, 0, 1, ev(0,0,0, 1,0,0,0,0));
    drv("k59_5",        0, 1, 5, 0, 0, 0, ev(0,0,5, 1,0,0,0,0));
    drv("k59_9",        0, 1, 9, 0, 0, 0, ev(0,5,9, 1,0,0,0,0));
    drv("start059",     0, 0, 0, 1, 0, 0, ev(0,5,9, 0,0,1,0,0));
    drv("run059",       0, 0, 0, 0, 0, 0, ev(0,5,9, 1,1,1,0,0));
    drv("zero_w_stop",  0, 0, 0, 0, 1, 1, ev(0,0,0, 1,0,0,1,0));
    drv("done_once2",   0, 0, 0, 0, 0, 0, ev(0,0,0, 1,0,0,0,0));
    drv("key_zero",     0, 1, 0, 0, 0, 0, ev(0,0,0, 1,0,0,0,0));
    drv("all_zero_st",  0, 0, 0, 1, 0, 0, ev(0,0,0, 1,0,0,0,1));
    drv("stop_beats_st",0, 0, 0, 1, 1, 0, ev(0,0,0, 1,0,0,0,0));
    drv("idle_start2",  0, 0, 0, 1, 0, 0, ev(0,0,0, 1,0,0,0,0));
    drv("k1234_1",      0, 1, 1, 0, 0, 0, ev(0,0,1, 1,0,0,0,0));
    drv("k1234_2",      0, 1, 2, 0, 0, 0, ev(0,1,2, 1,0,0,0,0));
    drv("k1234_3",      0, 1, 3, 0, 0, 0, ev(1,2,3, 1,0,0,0,0));
    drv("k1234_4",      0, 1, 4, 0, 0, 0, ev(2,3,4, 1,0,0,0,0));
    drv("start_b",      0, 0, 0, 1, 0, 0, ev(2,3,4, 0,0,1,0,0));
    drv("run_b",        0, 0, 0, 0, 0, 0, ev(2,3,4, 1,1,1,0,0));
    drv("clr_mid_run",  1, 0, 0, 0, 1, 0, ev(0,0,0, 1,0,0,0,0));
    drv("after_clr",    0, 0, 0, 0, 0, 0, ev(0,0,0, 1,0,0,0,0));
    @(negedge clk);
    check_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
